// File: rtl/pipe_elastic_buf.sv
// pipe_elastic_buf: DEPTH-entry FIFO stage register with valid/ready and flush.
// Define PIPE_ELASTIC_BUF_READY_LOOKAHEAD_EN to let a full buffer accept while popping.
module pipe_elastic_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 2,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign count_o = count;
  assign out_valid_o = count != '0;
  assign out_data_o = mem[rd_ptr];
  assign almost_full_o = count >= CW'(AFULL_LVL);
`ifdef PIPE_ELASTIC_BUF_READY_LOOKAHEAD_EN
  // combinational out_ready_i -> in_ready_o path: a pop frees the slot being filled
  assign in_ready_o = (count < CW'(DEPTH)) || out_ready_i;
`else
  assign in_ready_o = count < CW'(DEPTH);
`endif
  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop = out_valid_o && out_ready_i && !flush_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_pipe_elastic_buf.sv
// tb_pipe_elastic_buf: table vectors plus scoreboard over four buffer depths sharing one stimulus.
module tb_pipe_elastic_buf;
`ifdef PIPE_ELASTIC_BUF_READY_LOOKAHEAD_EN
  localparam bit LA = 1'b1;
`else
  localparam bit LA = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic rdy [4], ov [4], af [4];
  logic [63:0] dout [4];
  logic [3:0] cnt [4];
  int sel = 0, checks = 0, errors = 0;
  logic [63:0] q [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 4;
    localparam int A = g == 2 ? 1 : D - 1;
    logic [$clog2(D+1)-1:0] c;
    assign cnt[g] = 4'(c);
    pipe_elastic_buf #(.DATA_W(64), .DEPTH(D), .AFULL_LVL(A)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy[g]),
      .in_data_i(in_data), .out_valid_o(ov[g]), .out_ready_i(out_ready), .out_data_o(dout[g]),
      .count_o(c), .almost_full_o(af[g]));
  end
  typedef struct {bit v; logic [63:0] d; bit r; int c; bit o; bit rd; bit a;} row_t;
  row_t tbl [$];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h expected %0h", nm, sel, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (rst || flush) q.delete();
    else begin
      if (ov[sel] && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected (dut %0d): got %0h expected nothing", sel, dout[sel]);
        end else chk("pop_data", dout[sel], q.pop_front());
      end
      if (in_valid && rdy[sel]) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set(bit v, logic [63:0] d, bit r, bit f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
  endtask
  task automatic do_reset();
    set(0, 0, 0, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete();
  endtask
  task automatic run(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      set(tbl[i].v, tbl[i].d, tbl[i].r, 0);
      #1;
      chk($sformatf("row%0d_count", i), cnt[sel], 64'(tbl[i].c));
      chk($sformatf("row%0d_valid", i), ov[sel], tbl[i].o);
      chk($sformatf("row%0d_ready", i), rdy[sel], tbl[i].rd);
      chk($sformatf("row%0d_afull", i), af[sel], tbl[i].a);
      tick();
    end
  endtask
  initial begin
    int k, n;
    tbl.push_back('{1, 64'h11, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 64'h22, 1, 1, 1, 1, 1});
    tbl.push_back('{1, 64'h33, 1, 1, 1, 1, 1});
    tbl.push_back('{0, 64'h0, 1, 1, 1, 1, 1});
    tbl.push_back('{0, 64'h0, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 64'hA, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 64'hB, 0, 1, 1, 1, 0});
    tbl.push_back('{1, 64'hC, 0, 2, 1, 1, 1});
    tbl.push_back('{1, 64'hD, 0, 3, 1, 0, 1});
    tbl.push_back('{0, 64'h0, 1, 3, 1, LA, 1});
    tbl.push_back('{0, 64'h0, 1, 2, 1, 1, 1});
    tbl.push_back('{1, 64'hE, 1, 1, 1, 1, 0});
    tbl.push_back('{0, 64'h0, 1, 1, 1, 1, 0});
    tbl.push_back('{0, 64'h0, 0, 0, 0, 1, 0});
    do_reset();
    sel = 0;
    chk("rst_valid", ov[0], 0);
    chk("rst_count", cnt[0], 0);
    chk("rst_data", dout[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_afull", af[0], 0);
    run(0, 4);
    chk("stream_drained", q.size(), 0);
    do_reset();
    sel = 1;
    run(5, 13);
    chk("bp_drained", q.size(), 0);
    do_reset();
    sel = 2;
    k = 0;
    n = 0;
    while (k < 4 && n < 20) begin
      set(1, 64'(k + 1), 1, 0);
      #1;
      if (rdy[2]) k++;
      tick();
      n++;
    end
    chk("d1_accepts", k, 4);
    chk("d1_cycles", n, LA ? 4 : 7);
    set(0, 0, 1, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++) tick();
    chk("d1_drained", q.size(), 0);
    chk("d1_count", cnt[2], 0);
    do_reset();
    sel = 3;
    for (int i = 0; i < 3; i++) begin
      set(1, 64'h70 + 64'(i), 0, 0);
      tick();
    end
    chk("fl_count_before", cnt[3], 3);
    chk("fl_head_before", dout[3], 64'h70);
    set(1, 64'h99, 1, 1);
    tick();
    set(0, 0, 0, 0);
    #1;
    chk("fl_count", cnt[3], 0);
    chk("fl_valid", ov[3], 0);
    set(1, 64'h55, 0, 0);
    tick();
    set(0, 0, 0, 0);
    #1;
    chk("fl_after_valid", ov[3], 1);
    chk("fl_after_count", cnt[3], 1);
    chk("fl_after_data", dout[3], 64'h55);
    set(0, 0, 1, 0);
    tick();
    chk("fl_drained", q.size(), 0);
    chk("fl_empty", ov[3], 0);
    do_reset();
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      set(1, 64'hC0 + 64'(i), 0, 0);
      tick();
    end
    chk("rp_count_before", cnt[0], 2);
    set(1, 64'hEE, 1, 1);
    rst = 1;
    tick();
    rst = 0;
    set(0, 0, 0, 0);
    #1;
    chk("rp_count", cnt[0], 0);
    chk("rp_valid", ov[0], 0);
    chk("rp_data", dout[0], 0);
    chk("rp_afull", af[0], 0);
    chk("rp_ready", rdy[0], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_elastic_buf.md
Name: pipe_elastic_buf

Overview:
Parametrised elastic pipeline buffer for the in-order pipe, placed between two stages (e.g. ID->EX, EX->WB) in place of a single-entry valid/ready stage register. Holds up to DEPTH payloads of DATA_W bits in FIFO order with a valid/ready handshake on both sides and a pipeline flush. Output is always register-driven, so there is no combinational path from in_data_i or in_valid_i to out_*. DEPTH=1 degenerates to a classic one-entry stage register.

Parameters:
DATA_W, 64, payload width in bits (packed uop info plus operands); must be >= 1
DEPTH, 2, number of entries; must be >= 1; need not be a power of two
AFULL_LVL, DEPTH-1, occupancy at or above which almost_full_o is asserted; range 1..DEPTH

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  drop all held entries this cycle
in_valid_i  in  1  upstream payload valid
in_ready_o  out  1  buffer can accept this cycle
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  head entry valid
out_ready_i  in  1  downstream accepts the head
out_data_o  out  DATA_W  head entry payload
count_o  out  $clog2(DEPTH+1)  current occupancy
almost_full_o  out  1  count_o >= AFULL_LVL

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i. The clock and reset port names follow the codebase convention.
- Reset: count_o=0, out_valid_o=0, almost_full_o=0, rd/wr pointers=0, all storage cleared to 0, so out_data_o=0.
- push = in_valid_i && in_ready_o && !flush_i; pop = out_valid_o && out_ready_i && !flush_i.
- out_valid_o = (count_o != 0). out_data_o = mem[rd_ptr]. Both depend on state only.
- Latency: a payload pushed in cycle t is presented at out_*_o in cycle t+1 at the earliest. There is no same-cycle passthrough.
- Ordering is strict FIFO. There is no duplication or loss except on flush.
- Pointers: wr_ptr advances on push and rd_ptr on pop. Each wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Count update: push only +1; pop only -1; push and pop together leave the count unchanged, with the new entry written at wr_ptr and the head advanced.
- Empty (count 0): pop is impossible. A push makes out_valid_o=1 on the next cycle.
- Full (count DEPTH): in_ready_o behaviour is set by the optional feature below.
- Flush: when flush_i=1 on a clock edge, count becomes 0 and both pointers return to 0. Any push or pop offered in that cycle has no effect; the handshakes are ignored. out_valid_o=0 from the next cycle.
- Storage contents are not cleared by flush.
- Reset has priority over flush. Reset or flush in the middle of a stream simply empties the buffer, and the next push lands at entry 0.
- in_ready_o is not gated by flush_i. Upstream treats a flush cycle as a killed transfer.
- almost_full_o is purely a function of the registered count.

Optional Feature:
Macro PIPE_ELASTIC_BUF_READY_LOOKAHEAD_EN.
- Defined: in_ready_o = (count_o < DEPTH) || out_ready_i. When full, a simultaneous pop frees a slot, allowing push and pop in the same cycle at full occupancy with the count staying at DEPTH. This keeps full throughput at DEPTH=1 but adds a combinational path from out_ready_i to in_ready_o.
- Undefined: in_ready_o = (count_o < DEPTH), which is purely registered. A full buffer accepts nothing until the cycle after a pop, and DEPTH=1 runs at half throughput under back-pressure.

Test Plan:
- Reset then idle (DEPTH=2, DATA_W=64): hold rst_i=1 for 2 cycles, then release -> out_valid_o=0, count_o=0, out_data_o=0, in_ready_o=1, almost_full_o=0.
- Stream with out_ready_i=1: push 0x11, 0x22, 0x33 on consecutive cycles -> out emits 0x11, 0x22, 0x33 on cycles t+1, t+2, t+3; count_o stays 1 throughout.
- Back-pressure fill (out_ready_i=0, DEPTH=3): push 0xA, 0xB, 0xC -> count_o=1,2,3; almost_full_o=1 at count 2; in_ready_o=0 at 3. Then release out_ready_i -> drains 0xA, 0xB, 0xC in order, wrap-around is correct, and a fourth push after the wrap lands in entry 0.
- Full with simultaneous push+pop (DEPTH=1): with lookahead defined, push 1..4 with out_ready_i=1 -> one item per cycle and count_o stays 1. With the macro undefined -> an accept every other cycle and all values still in order.
- Flush mid-stream (DEPTH=4): hold 3 entries, assert flush_i together with a push of 0x99 and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, 0x99 is not stored. A following push of 0x55 appears at out_data_o one cycle later.
- Reset priority: assert rst_i and flush_i together with 2 entries held -> full reset state, including out_data_o=0.
